// File: rtl/register_file_scoreboard.sv
// 8x16 architectural register file with a per-register in-flight write counter.
// Optional write-through bypass of data and pending when REG_FILE_BYPASS_EN is defined.
module register_file_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int PEND_W   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        reg_write_en,
   input  logic [$clog2(NUM_REGS)-1:0] reg_write_dest,
   input  logic [DATA_W-1:0]           reg_write_data,
   input  logic [$clog2(NUM_REGS)-1:0] reg_read_addr_1,
   output logic [DATA_W-1:0]           reg_read_data_1,
   input  logic [$clog2(NUM_REGS)-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0]           reg_read_data_2,
   input  logic                        issue_en,
   input  logic [$clog2(NUM_REGS)-1:0] issue_dest,
   output logic                        pending_1,
   output logic                        pending_2,
   output logic [NUM_REGS-1:0]         pending_mask,
   output logic                        sb_overflow,
   output logic                        sb_underflow
);

   localparam int AW = $clog2(NUM_REGS);
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [PEND_W-1:0] cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] dec;

   // r0 never gets inc/dec, so its counter stays at zero forever.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         inc[i] = issue_en && (issue_dest == AW'(i));
         dec[i] = reg_write_en && (reg_write_dest == AW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
            cnt[i]  <= '0;
         end
         sb_overflow  <= 1'b0;
         sb_underflow <= 1'b0;
      end else begin
         if (reg_write_en && reg_write_dest != '0)
            regs[reg_write_dest] <= reg_write_data;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (inc[i] && !dec[i]) begin
               if (cnt[i] == CNT_MAX) sb_overflow <= 1'b1;
               else                   cnt[i] <= cnt[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
               if (cnt[i] == '0) sb_underflow <= 1'b1;
               else              cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 1; i < NUM_REGS; i++)
         pending_mask[i] = (cnt[i] != '0);
   end

`ifdef REG_FILE_BYPASS_EN
   // A retiring write that drops the count from 1 to 0 hides the hazard a cycle early.
   logic [NUM_REGS-1:0] retire_clr;
   always_comb begin
      retire_clr = '0;
      for (int i = 1; i < NUM_REGS; i++)
         retire_clr[i] = !rst && dec[i] && !inc[i] && (cnt[i] == CNT_ONE);
   end
`endif

   always_comb begin
      reg_read_data_1 = (reg_read_addr_1 == '0) ? '0 : regs[reg_read_addr_1];
      reg_read_data_2 = (reg_read_addr_2 == '0) ? '0 : regs[reg_read_addr_2];
      pending_1 = pending_mask[reg_read_addr_1];
      pending_2 = pending_mask[reg_read_addr_2];
`ifdef REG_FILE_BYPASS_EN
      if (!rst && reg_write_en && reg_write_dest != '0 && reg_write_dest == reg_read_addr_1)
         reg_read_data_1 = reg_write_data;
      if (!rst && reg_write_en && reg_write_dest != '0 && reg_write_dest == reg_read_addr_2)
         reg_read_data_2 = reg_write_data;
      if (retire_clr[reg_read_addr_1]) pending_1 = 1'b0;
      if (retire_clr[reg_read_addr_2]) pending_2 = 1'b0;
`endif
   end

endmodule
